// File: rtl/xfer_worker_fsm.sv
// xfer_worker_fsm
// Worker state machine behind the master's start/busy/done handshake.
// One accepted start runs a burst of `len` words over a req/ack handshake.
// Each word has its own ack time-out, so a stalled peer cannot hang the master.
// All outputs come straight from registers.

module xfer_worker_fsm #(
   parameter int LEN_W       = 8,
   parameter int ACK_TIMEOUT = 1000,
   parameter int TO_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   output logic             req,
   output logic [LEN_W-1:0] addr,
   input  logic             ack,
   output logic [1:0]       state,
   output logic             busy,
   output logic             done,
   output logic             err
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_WAIT  = 2'b10,
      ST_ERROR = 2'b11
   } state_t;

   // The counter value seen on the last allowed ack-less WAIT cycle.
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

   state_t           state_r;
   logic             req_r;
   logic [LEN_W-1:0] addr_r;
   logic             busy_r;
   logic             done_r;
   logic             err_r;
   logic [LEN_W-1:0] idx_r;
   logic [LEN_W-1:0] len_r;
   logic [TO_W-1:0]  to_cnt_r;

   // Next word index, one bit wider so that the compare against the latched
   // length cannot alias when the index would reach 2^LEN_W.
   logic [LEN_W:0]   idx_nxt_s;

   // Next word index, computed at LEN_W+1 bits.
   always_comb begin
      idx_nxt_s = {1'b0, idx_r} + {{LEN_W{1'b0}}, 1'b1};
   end

   // Burst FSM: the state and every output register are updated together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= ST_IDLE;
         req_r    <= 1'b0;
         addr_r   <= {LEN_W{1'b0}};
         busy_r   <= 1'b0;
         done_r   <= 1'b1;
         err_r    <= 1'b0;
         idx_r    <= {LEN_W{1'b0}};
         len_r    <= {LEN_W{1'b0}};
         to_cnt_r <= {TO_W{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  // Any accepted start clears the sticky error; a zero-length
                  // start completes on the spot and leaves busy/done alone.
                  err_r <= 1'b0;
                  if (len != {LEN_W{1'b0}}) begin
                     len_r   <= len;
                     idx_r   <= {LEN_W{1'b0}};
                     busy_r  <= 1'b1;
                     done_r  <= 1'b0;
                     state_r <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               // One-cycle bubble between words: present the word, arm timer.
               addr_r   <= idx_r;
               req_r    <= 1'b1;
               to_cnt_r <= {TO_W{1'b0}};
               state_r  <= ST_WAIT;
            end
            ST_WAIT: begin
               // ack is checked first so it wins over the time-out terminal count.
               if (ack) begin
                  req_r <= 1'b0;
                  idx_r <= idx_nxt_s[LEN_W-1:0];
                  if (idx_nxt_s == {1'b0, len_r}) begin
                     busy_r  <= 1'b0;
                     done_r  <= 1'b1;
                     state_r <= ST_IDLE;
                  end else begin
                     state_r <= ST_ISSUE;
                  end
               end else begin
                  to_cnt_r <= to_cnt_r + TO_W'(1);
                  if (to_cnt_r == TO_LAST) begin
                     req_r   <= 1'b0;
                     err_r   <= 1'b1;
                     state_r <= ST_ERROR;
                  end
               end
            end
            ST_ERROR: begin
               // Report completion one cycle after the abort; err stays set.
               busy_r  <= 1'b0;
               done_r  <= 1'b1;
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
               req_r   <= 1'b0;
               busy_r  <= 1'b0;
               done_r  <= 1'b1;
            end
         endcase
      end
   end

   assign state = state_r;
   assign req   = req_r;
   assign addr  = addr_r;
   assign busy  = busy_r;
   assign done  = done_r;
   assign err   = err_r;

endmodule
